idma_rd_burst_gen: RTL and testbench
====================================

// Module: idma_rd_burst_gen
// PURPOSE
//  Read-DMA burst generator, directly upstream of the 4K-crossing AXI AR splitter.
//  Accepts one read command (start address, total 128b beats) and chops it into
//  INCR bursts of <=MAX_BURST beats on the dma_trans_burst_* request interface.
//  Tracks outstanding bursts, drives x_burst_arvld_disable for flow control and
//  pulses cmd_done once all data for the command has returned.
// PARAMETERS
//  MAX_BURST   16  max beats per burst, 1..16 (len field = beats-1, 4 bits)
//  MAX_OUTSTD  4   max bursts accepted downstream but not yet data-complete, 1..15
//  CNT_W       16  width of cmd_beats / remaining-beat counter
// PORTS
//  aclk                    in   1      clock
//  aresetn                 in   1      async active-low reset
//  cmd_valid               in   1      command request
//  cmd_ready               out  1      command accept (IDLE only)
//  cmd_addr                in   32     start byte address; bits[3:0] ignored (forced 0)
//  cmd_beats               in   CNT_W  total 16-byte beats; 0 allowed
//  dma_trans_burst_avalid  out  1      burst request valid
//  dma_trans_burst_addr    out  32     burst start address, 16B aligned
//  dma_trans_burst_len     out  4      beats-1
//  x_burst_arvld_disable   out  1      outstanding limit reached, blocks new AR issue
//  dma_xaddr_burst_ok      in   1      pulse: current burst fully accepted downstream
//  axi_burst_xdata_ok      in   1      pulse: all data of one original burst returned
//  busy                    out  1      state != IDLE
//  cmd_done                out  1      1-cycle pulse, command complete
//  err_underflow           out  1      sticky: xdata_ok seen with zero outstanding
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except cmd_ready=1; counters cleared. Reset
//   mid-command discards it; no cmd_done is produced.
//  FSM IDLE -> BURST -> DRAIN -> IDLE (registered state; outputs decoded from regs).
//  IDLE: cmd_ready=1. On cmd_valid&cmd_ready latch addr={cmd_addr[31:4],4'h0},
//   rem=cmd_beats. rem!=0 -> BURST; rem==0 -> DRAIN (cmd_done one cycle later if
//   outstanding==0).
//  BURST: n = min(rem, MAX_BURST); avalid=1, addr=cur_addr, len=n-1, held stable
//   until dma_xaddr_burst_ok. avalid is NOT gated by x_burst_arvld_disable; the
//   downstream stage gates issue.
//   On ok: cur_addr += n<<4 (mod 2^32 wrap), rem -= n, outstanding++.
//   rem==n at ok -> DRAIN, else stay BURST. Next request visible the cycle after ok
//   (1-cycle bubble); avalid may stay high across the bubble only if the next burst
//   is already registered.
//  DRAIN: avalid=0; when outstanding==0 -> cmd_done=1 for one cycle, go IDLE.
//   cmd_ready returns the cycle after cmd_done.
//  Outstanding counter: ok&xdata_ok same cycle -> unchanged. xdata_ok at 0 ->
//   counter stays 0, err_underflow set (cleared only by reset). ok at MAX_OUTSTD
//   is accepted and counts (saturates at 15); downstream must honour the disable.
//  x_burst_arvld_disable = (outstanding >= MAX_OUTSTD), combinational from the
//   registered count.
//  Cross-4K splitting happens downstream; this block emits one request per burst
//   and expects exactly one dma_xaddr_burst_ok and one axi_burst_xdata_ok per burst.
// TESTING
//  1 addr=0x1000, beats=40, MAX_BURST=16 -> bursts (0x1000,len15),(0x1100,15),
//    (0x1200,7); cmd_done after 3rd xdata_ok.
//  2 addr=0x0FC8 (low bits ignored -> 0x0FC0), beats=5 -> single burst 0x0FC0,len4.
//  3 beats=0 -> no avalid, cmd_done pulse; cmd_ready back high next cycle.
//  4 MAX_OUTSTD=2, xdata_ok withheld -> disable=1 after 2nd ok; one xdata_ok ->
//    disable=0.
//  5 ok and xdata_ok same cycle with outstanding=1 -> stays 1; xdata_ok at 0 ->
//    err_underflow=1.
//  6 addr=0xFFFF_FFC0, beats=8 -> 1st burst 0xFFFF_FFC0,len7; aresetn low mid-BURST
//    -> IDLE, avalid=0, no cmd_done.

Source files
------------

// File: rtl/idma_rd_burst_gen.sv
// Read-DMA burst generator: chops one read command into INCR bursts of up to
// MAX_BURST 16-byte beats, tracks outstanding bursts and signals command completion.
module idma_rd_burst_gen #(
  parameter int MAX_BURST  = 16,
  parameter int MAX_OUTSTD = 4,
  parameter int CNT_W      = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [CNT_W-1:0] cmd_beats,
  output logic             dma_trans_burst_avalid,
  output logic [31:0]      dma_trans_burst_addr,
  output logic [3:0]       dma_trans_burst_len,
  output logic             x_burst_arvld_disable,
  input  logic             dma_xaddr_burst_ok,
  input  logic             axi_burst_xdata_ok,
  output logic             busy,
  output logic             cmd_done,
  output logic             err_underflow
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  localparam logic [CNT_W-1:0] MAXB = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [3:0]       OMAX = 4'(MAX_OUTSTD);

  state_t           state, state_nxt;
  logic [31:0]      cur_addr;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] n_beats;
  logic [3:0]       outstd;
  logic             accept, burst_ok;

  assign n_beats  = (rem > MAXB) ? MAXB : rem;
  assign accept   = cmd_valid && (state == IDLE);
  assign burst_ok = dma_xaddr_burst_ok && (state == BURST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (cmd_beats == '0) ? DRAIN : BURST;
      BURST:   if (burst_ok && (rem == n_beats)) state_nxt = DRAIN;
      DRAIN:   if (outstd == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      cur_addr <= '0;
      rem      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cur_addr <= {cmd_addr[31:4], 4'h0};
        rem      <= cmd_beats;
      end else if (burst_ok) begin
        // address wraps modulo 2^32 by natural 32-bit truncation
        cur_addr <= cur_addr + 32'({n_beats, 4'h0});
        rem      <= rem - n_beats;
      end
    end
  end

  // simultaneous accept and data return cancel; an unmatched return at zero is flagged
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      outstd        <= '0;
      err_underflow <= 1'b0;
    end else begin
      case ({burst_ok, axi_burst_xdata_ok})
        2'b10:   if (outstd != 4'hF) outstd <= outstd + 4'd1;
        2'b01: begin
          if (outstd != 4'd0) outstd <= outstd - 4'd1;
          else                err_underflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready              = (state == IDLE);
  assign busy                   = (state != IDLE);
  assign dma_trans_burst_avalid = (state == BURST);
  assign dma_trans_burst_addr   = (state == BURST) ? cur_addr : 32'h0;
  assign dma_trans_burst_len    = (state == BURST) ? 4'(n_beats - ONE) : 4'h0;
  assign x_burst_arvld_disable  = (outstd >= OMAX);
  assign cmd_done               = (state == DRAIN) && (outstd == 4'd0);

endmodule

// File: tb/tb_idma_rd_burst_gen.sv
// Bench for idma_rd_burst_gen: random commands against a burst-list reference
// model with a randomly timed downstream, followed by directed corner cases.
module tb_idma_rd_burst_gen;
  localparam int MAXB = 16;
  localparam int MAXO = 2;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic        avalid, disable_o, ok, xd, busy, cmd_done, err;
  logic [31:0] baddr;
  logic [3:0]  blen;

  int n_chk = 0;
  int n_fail = 0;
  int mo = 0;

  always #5 aclk = ~aclk;

  idma_rd_burst_gen #(.MAX_BURST(MAXB), .MAX_OUTSTD(MAXO), .CNT_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .dma_trans_burst_avalid(avalid), .dma_trans_burst_addr(baddr),
    .dma_trans_burst_len(blen), .x_burst_arvld_disable(disable_o),
    .dma_xaddr_burst_ok(ok), .axi_burst_xdata_ok(xd),
    .busy(busy), .cmd_done(cmd_done), .err_underflow(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, " busy"},      32'(busy),      32'd0);
    chk({tag, " avalid"},    32'(avalid),    32'd0);
    chk({tag, " cmd_done"},  32'(cmd_done),  32'd0);
  endtask

  task automatic issue_cmd(input logic [31:0] a, input logic [15:0] b);
    @(negedge aclk);
    chk("issue cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_beats = b;
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  // Reference: burst list from plain arithmetic; the bench plays the downstream
  // stage, honouring the disable and returning data in random order of time.
  task automatic run_cmd(input logic [31:0] a_in, input logic [15:0] beats, input bit slow);
    logic [31:0] qa[$];
    logic [3:0]  ql[$];
    logic [31:0] a;
    int r, n, issued, cyc;
    bit done, eo, ex;
    a = a_in & 32'hFFFF_FFF0;
    r = beats;
    while (r > 0) begin
      n = (r > MAXB) ? MAXB : r;
      qa.push_back(a); ql.push_back(4'(n - 1));
      a = a + 32'(n * 16);
      r -= n;
    end
    issue_cmd(a_in, beats);
    issued = 0; done = 0; cyc = 0;
    while (!done && cyc < 3000) begin
      chk("run avalid", 32'(avalid), 32'(issued < qa.size()));
      if (issued < qa.size()) begin
        chk("run addr", baddr, qa[issued]);
        chk("run len",  32'(blen), 32'(ql[issued]));
      end
      chk("run disable",  32'(disable_o), 32'(mo >= MAXO));
      chk("run busy",     32'(busy), 32'd1);
      chk("run err",      32'(err), 32'd0);
      chk("run cmd_done", 32'(cmd_done), 32'(issued == qa.size() && mo == 0));
      if (issued == qa.size() && mo == 0) begin
        done = 1;
        ok = 1'b0; xd = 1'b0;
      end else begin
        eo = (issued < qa.size()) && (mo < MAXO) && (slow ? ($urandom % 4 == 0) : ($urandom % 3 != 0));
        ex = (mo > 0) && ($urandom % 2 == 0);
        ok = eo; xd = ex;
      end
      @(negedge aclk);
      ok = 1'b0; xd = 1'b0;
      if (!done) begin
        if (eo) begin issued++; mo++; end
        if (ex) mo--;
      end
      cyc++;
    end
    if (!done) chk("run timeout", 32'd0, 32'd1);
    idle_chk("post-done");
  endtask

  task automatic pulse(input bit o, input bit x);
    ok = o; xd = x;
    @(negedge aclk);
    ok = 1'b0; xd = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0; ok = 1'b0; xd = 1'b0;
    repeat (3) @(negedge aclk);
    idle_chk("reset");
    chk("reset disable", 32'(disable_o), 32'd0);
    chk("reset err",     32'(err), 32'd0);
    chk("reset addr",    baddr, 32'd0);
    chk("reset len",     32'(blen), 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    idle_chk("after reset");

    // directed scenario 1 checked against literal burst values
    issue_cmd(32'h1000, 16'd40);
    chk("t1 b0 addr", baddr, 32'h1000); chk("t1 b0 len", 32'(blen), 32'd15);
    pulse(1, 0);
    chk("t1 b1 addr", baddr, 32'h1100); chk("t1 b1 len", 32'(blen), 32'd15);
    chk("t1 disable", 32'(disable_o), 32'd0);
    pulse(1, 1);
    chk("t1 b2 addr", baddr, 32'h1200); chk("t1 b2 len", 32'(blen), 32'd7);
    pulse(1, 0);
    chk("t1 drain avalid", 32'(avalid), 32'd0);
    chk("t1 disable full", 32'(disable_o), 32'd1);
    pulse(0, 1);
    chk("t1 not done", 32'(cmd_done), 32'd0);
    pulse(0, 1);
    chk("t1 done", 32'(cmd_done), 32'd1);
    @(negedge aclk);
    idle_chk("t1 idle");

    // random commands, including near-top addresses that wrap
    for (int i = 0; i < 25; i++) begin
      logic [31:0] a;
      logic [15:0] b;
      a = (i % 5 == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom;
      b = (i % 7 == 0) ? 16'd0 : 16'($urandom_range(1, 90));
      run_cmd(a, b, i[0]);
    end
    run_cmd(32'h0000_0FC8, 16'd5, 1'b0);
    run_cmd(32'h0000_0000, 16'd0, 1'b0);
    run_cmd(32'hFFFF_FFC0, 16'd40, 1'b1);

    // scenario 2 low bits ignored
    issue_cmd(32'h0FC8, 16'd5);
    chk("t2 addr", baddr, 32'h0FC0); chk("t2 len", 32'(blen), 32'd4);
    pulse(1, 0); pulse(0, 1);
    chk("t2 done", 32'(cmd_done), 32'd1);
    @(negedge aclk);

    // scenario 3 zero beats
    issue_cmd(32'h4000, 16'd0);
    chk("t3 avalid", 32'(avalid), 32'd0);
    chk("t3 done", 32'(cmd_done), 32'd1);
    @(negedge aclk);
    idle_chk("t3 ready next");

    // scenario 5: ok and xdata together hold the count at 1
    issue_cmd(32'h8000, 16'd32);
    pulse(1, 0);
    pulse(1, 1);
    chk("t5 still outstanding", 32'(cmd_done), 32'd0);
    chk("t5 disable", 32'(disable_o), 32'd0);
    pulse(0, 1);
    chk("t5 done", 32'(cmd_done), 32'd1);
    @(negedge aclk);
    chk("t5 err before", 32'(err), 32'd0);
    pulse(0, 1);
    chk("t5 underflow", 32'(err), 32'd1);
    repeat (2) @(negedge aclk);
    chk("t5 underflow sticky", 32'(err), 32'd1);

    // scenario 6: wrap address, reset mid-burst discards the command
    issue_cmd(32'hFFFF_FFC0, 16'd8);
    chk("t6 addr", baddr, 32'hFFFF_FFC0); chk("t6 len", 32'(blen), 32'd7);
    chk("t6 avalid", 32'(avalid), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("t6 rst avalid", 32'(avalid), 32'd0);
    chk("t6 rst ready",  32'(cmd_ready), 32'd1);
    chk("t6 rst err",    32'(err), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      idle_chk("t6 after reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
